// File: rtl/freq_gate_gen.sv
// freq_gate_gen: gate window generator (exact clk-cycle gate, fixed gap) plus free-running square-wave test signal.
// Optional GATE_ALIGN_EN: gate opens only on a 0->1 edge of test_signal.
module freq_gate_gen #(
  parameter int CNT_W = 40,
  parameter int DIV_W = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] gate_ticks,
  input  logic [DIV_W-1:0] half_period,
  output logic             period,
  output logic             test_signal,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARM, GATE, GAP} state_t;
  state_t state_q, state_d, open_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DIV_W-1:0] div_q, div_d, h_q, h_d, h_eff;
  logic ts_q, ts_d, period_q, period_d, busy_q, busy_d, done_q, done_d;
  logic cfg_err_q, cfg_err_d, abort_q, abort_d, ts_rise;
`ifdef GATE_ALIGN_EN
  assign open_st = ARM;
`else
  assign open_st = GATE;
`endif
  // H is only re-sampled at a toggle, so a new half_period never cuts a phase short
  always_comb begin
    h_eff = (h_q == '0) ? half_period : h_q;
    div_d = div_q + DIV_W'(1);
    ts_d = ts_q;
    h_d = h_eff;
    if (half_period == '0) begin
      div_d = '0;
      ts_d = 1'b0;
      h_d = '0;
    end else if (div_q == h_eff - DIV_W'(1)) begin
      div_d = '0;
      ts_d = ~ts_q;
      h_d = half_period;
    end
    ts_rise = ~ts_q & ts_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    cfg_err_d = cfg_err_q;
    abort_d = abort_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) begin
        cfg_err_d = (gate_ticks == '0);
        if (gate_ticks != '0) begin
          cnt_d = gate_ticks;
          abort_d = 1'b0;
          state_d = open_st;
        end
      end
      ARM: state_d = stop ? IDLE : ts_rise ? GATE : ARM;
      GATE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (stop || cnt_q == CNT_W'(1)) begin
          state_d = GAP;
          gap_d = GW'(GAP_CYCLES - 1);
          abort_d = stop;
          done_d = ~stop;
        end
      end
      default: begin
        abort_d = abort_q | stop;
        gap_d = gap_q - GW'(1);
        if (gap_q == '0) begin
          state_d = IDLE;
          if (continuous && !stop && !abort_q) begin
            cfg_err_d = (gate_ticks == '0);
            cnt_d = gate_ticks;
            state_d = (gate_ticks == '0) ? IDLE : open_st;
          end
        end
      end
    endcase
    period_d = (state_d == GATE);
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gap_q <= '0;
      div_q <= '0;
      h_q <= '0;
      ts_q <= 1'b0;
      period_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      div_q <= div_d;
      h_q <= h_d;
      ts_q <= ts_d;
      period_q <= period_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
      abort_q <= abort_d;
    end
  end
  assign period = period_q;
  assign test_signal = ts_q;
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_freq_gate_gen.sv
// tb_freq_gate_gen: directed test of freq_gate_gen (default build, GAP_CYCLES=4).
module tb_freq_gate_gen;
  logic clk = 1'b0, rst, start, stop, continuous;
  logic [39:0] gate_ticks;
  logic [31:0] half_period;
  logic period, test_signal, busy, done, cfg_err;
  int tests = 0, fails = 0, rises = 0, r0, n;
  logic ts_prev = 1'b0;
  freq_gate_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .gate_ticks(gate_ticks), .half_period(half_period), .period(period),
    .test_signal(test_signal), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (period && test_signal && !ts_prev) rises++;
    ts_prev = test_signal;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic gate_len(output int c);
    c = 0;
    while (period === 1'b1 && c < 5000) begin
      c++;
      tick();
    end
  endtask
  task automatic low_len(output int c);
    c = 0;
    while (period === 1'b0 && c < 5000) begin
      c++;
      tick();
    end
  endtask
  task automatic toggle_gap(output int c);
    logic t;
    t = test_signal;
    c = 0;
    do begin
      tick();
      c++;
    end while (test_signal === t && c < 100);
  endtask
  initial begin
    rst = 1'b1; start = 0; stop = 0; continuous = 0; gate_ticks = 0; half_period = 0;
    repeat (3) tick();
    chk("rst_period", period, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_ts", test_signal, 0);
    rst = 1'b0;
    half_period = 5; gate_ticks = 100;
    tick();
    r0 = rises;
    pulse_start();
    chk("g100_busy_open", busy, 1);
    gate_len(n);
    chk("g100_len", n, 100);
    chk("g100_rises", rises - r0, 10);
    chk("g100_done", done, 1);
    repeat (3) tick();
    chk("g100_busy_gap", busy, 1);
    chk("g100_done_once", done, 0);
    tick();
    chk("g100_busy_end", busy, 0);
    gate_ticks = 1000;
    pulse_start();
    repeat (499) tick();
    chk("mid_period_pre", period, 1);
    rst = 1'b1;
    #1;
    chk("arst_period", period, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ts", test_signal, 0);
    tick();
    rst = 1'b0;
    pulse_start();
    gate_len(n);
    chk("g1000_len", n, 1000);
    repeat (4) tick();
    chk("g1000_idle", busy, 0);
    gate_ticks = 0;
    pulse_start();
    chk("cfg_err_set", cfg_err, 1);
    chk("cfg_err_period", period, 0);
    chk("cfg_err_busy", busy, 0);
    repeat (3) tick();
    chk("cfg_err_sticky", cfg_err, 1);
    gate_ticks = 8;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 0);
    chk("start_stop_cfg", cfg_err, 1);
    pulse_start();
    chk("cfg_err_clear", cfg_err, 0);
    gate_len(n);
    chk("g8_len", n, 8);
    repeat (4) tick();
    gate_ticks = 20; continuous = 1'b1;
    pulse_start();
    gate_len(n);
    chk("c_gate1", n, 20);
    chk("c_done1", done, 1);
    low_len(n);
    chk("c_gap1", n, 4);
    gate_len(n);
    chk("c_gate2", n, 20);
    low_len(n);
    chk("c_gap2", n, 4);
    repeat (5) tick();
    chk("c_gate3_open", period, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c_stop_period", period, 0);
    chk("c_stop_done", done, 0);
    chk("c_stop_busy", busy, 1);
    repeat (3) tick();
    chk("c_stop_gap_busy", busy, 1);
    tick();
    chk("c_stop_idle", busy, 0);
    repeat (10) tick();
    chk("c_no_restart", period, 0);
    continuous = 1'b0;
    half_period = 3;
    toggle_gap(n);
    toggle_gap(n);
    chk("h3_a", n, 3);
    toggle_gap(n);
    chk("h3_b", n, 3);
    half_period = 0;
    tick();
    chk("h0_low", test_signal, 0);
    repeat (10) tick();
    chk("h0_hold", test_signal, 0);
    half_period = 7;
    toggle_gap(n);
    chk("h7_first", n, 7);
    toggle_gap(n);
    chk("h7_a", n, 7);
    toggle_gap(n);
    chk("h7_b", n, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
